// File: rtl/end_game_sequencer_if.sv
// rtl/end_game_sequencer_if.sv - game-event inputs and banner/control outputs of the end-game sequencer
interface end_game_sequencer_if;
   logic startOfFrame;
   logic player_dead;
   logic enemies_cleared;
   logic restart_key;
   logic game_over;
   logic game_won;
   logic freeze_game;
   logic restart_game;

   // game logic side: raises events, consumes banner/freeze/restart controls
   modport master (
      output startOfFrame, player_dead, enemies_cleared, restart_key,
      input  game_over, game_won, freeze_game, restart_game
   );

   // sequencer side
   modport slave (
      input  startOfFrame, player_dead, enemies_cleared, restart_key,
      output game_over, game_won, freeze_game, restart_game
   );
endinterface

// File: rtl/end_game_sequencer.sv
// rtl/end_game_sequencer.sv - end-of-game freeze/banner/restart sequencer (optional blink: BANNER_BLINK_EN)
module end_game_sequencer #(
   parameter int FREEZE_FRAMES     = 60,
   parameter int MIN_BANNER_FRAMES = 120,
   parameter int BLINK_HALF_PERIOD = 30,
   parameter int CNT_WIDTH         = 8
) (
   input  logic                clk,
   input  logic                resetN,
   end_game_sequencer_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] FREEZE_LAST = CNT_WIDTH'(FREEZE_FRAMES - 1);
   localparam logic [CNT_WIDTH-1:0] BANNER_MIN  = CNT_WIDTH'(MIN_BANNER_FRAMES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

   // Reject frame counts the counter cannot represent.
   if (FREEZE_FRAMES < 1 || FREEZE_FRAMES > (2**CNT_WIDTH) - 1 ||
       MIN_BANNER_FRAMES > (2**CNT_WIDTH) - 1 ||
       BLINK_HALF_PERIOD < 1 || BLINK_HALF_PERIOD > (2**CNT_WIDTH) - 1) begin : g_bad_cfg
      $error("end_game_sequencer: frame parameters out of range for CNT_WIDTH");
   end

   typedef enum logic [1:0] {PLAY, FREEZE, BANNER, RESTART} state_t;

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic                 key_prev;
   logic                 key_rise;
   logic                 won_n;
   logic                 over_n;

   // Next state, latched result and frame counter; a transition clears the counter
   // and swallows any coincident startOfFrame.
   always_comb begin
      state_n  = state;
      won_n    = bus.game_won;
      key_rise = bus.restart_key & ~key_prev;
      case (state)
         PLAY: begin
            if (bus.player_dead) begin
               state_n = FREEZE;
               won_n   = 1'b0;
            end else if (bus.enemies_cleared) begin
               state_n = FREEZE;
               won_n   = 1'b1;
            end
         end
         FREEZE: begin
            if (bus.startOfFrame && cnt == FREEZE_LAST) begin
               state_n = BANNER;
            end
         end
         BANNER: begin
            if (key_rise && cnt >= BANNER_MIN) begin
               state_n = RESTART;
               won_n   = 1'b0;
            end
         end
         RESTART: begin
            state_n = PLAY;
            won_n   = 1'b0;
         end
         default: begin
            state_n = PLAY;
            won_n   = 1'b0;
         end
      endcase

      if (state_n != state) begin
         cnt_n = '0;
      end else if (bus.startOfFrame && cnt != CNT_MAX) begin
         cnt_n = cnt + 1'b1;
      end else begin
         cnt_n = cnt;
      end
   end

`ifdef BANNER_BLINK_EN
   localparam logic [CNT_WIDTH-1:0] BLINK_LAST = CNT_WIDTH'(BLINK_HALF_PERIOD - 1);

   logic                 phase, phase_n;
   logic [CNT_WIDTH-1:0] blink_cnt, blink_cnt_n;

   // Blink phase: visible on BANNER entry, toggles every BLINK_HALF_PERIOD frames in BANNER.
   always_comb begin
      phase_n     = phase;
      blink_cnt_n = blink_cnt;
      if (state_n != BANNER || state != BANNER) begin
         phase_n     = 1'b1;
         blink_cnt_n = '0;
      end else if (bus.startOfFrame) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
         end else begin
            blink_cnt_n = blink_cnt + 1'b1;
         end
      end
      over_n = (state_n == BANNER) & phase_n;
   end

   // Blink phase registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         phase     <= 1'b1;
         blink_cnt <= '0;
      end else begin
         phase     <= phase_n;
         blink_cnt <= blink_cnt_n;
      end
   end
`else
   // Steady banner for the whole BANNER state.
   always_comb begin
      over_n = (state_n == BANNER);
   end
`endif

   // State, counter, key history and registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state            <= PLAY;
         cnt              <= '0;
         key_prev         <= 1'b0;
         bus.game_over    <= 1'b0;
         bus.game_won     <= 1'b0;
         bus.freeze_game  <= 1'b0;
         bus.restart_game <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         key_prev         <= bus.restart_key;
         bus.game_over    <= over_n;
         bus.game_won     <= won_n;
         bus.freeze_game  <= (state_n != PLAY);
         bus.restart_game <= (state_n == RESTART);
      end
   end

endmodule

// File: tb/tb_end_game_sequencer.sv
// tb/tb_end_game_sequencer.sv - self-checking bench for end_game_sequencer against a frame-level model
module tb_end_game_sequencer;
   localparam int FF  = 3;
   localparam int MB  = 4;
   localparam int BH  = 2;
   localparam int CW  = 8;
   localparam int SOF = 10;

   localparam int M_PLAY    = 0;
   localparam int M_FREEZE  = 1;
   localparam int M_BANNER  = 2;
   localparam int M_RESTART = 3;

   logic clk    = 1'b0;
   logic resetN = 1'b0;
   logic pd = 1'b0, ec = 1'b0, rk = 1'b0;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   int m_mode;
   int m_frames;
   bit m_won;
   bit m_kprev;

   end_game_sequencer_if bus();

   end_game_sequencer #(
      .FREEZE_FRAMES(FF), .MIN_BANNER_FRAMES(MB),
      .BLINK_HALF_PERIOD(BH), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic exp_over();
      if (m_mode != M_BANNER) return 1'b0;
`ifdef BANNER_BLINK_EN
      return ((m_frames / BH) % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      check("game_over",    bus.game_over,    exp_over());
      check("game_won",     bus.game_won,     m_won);
      check("freeze_game",  bus.freeze_game,  m_mode != M_PLAY);
      check("restart_game", bus.restart_game, m_mode == M_RESTART);
   endtask

   task automatic model_reset();
      m_mode   = M_PLAY;
      m_frames = 0;
      m_won    = 1'b0;
      m_kprev  = 1'b0;
   endtask

   task automatic model_edge(input bit sof);
      int nm;
      nm = m_mode;
      case (m_mode)
         M_PLAY: begin
            if (pd) begin
               nm = M_FREEZE; m_won = 1'b0;
            end else if (ec) begin
               nm = M_FREEZE; m_won = 1'b1;
            end
         end
         M_FREEZE:  if (sof && m_frames + 1 == FF) nm = M_BANNER;
         M_BANNER:  if (rk && !m_kprev && m_frames >= MB) begin
                       nm = M_RESTART; m_won = 1'b0;
                    end
         default: begin
            nm = M_PLAY; m_won = 1'b0;
         end
      endcase
      if (nm != m_mode) m_frames = 0;
      else if (sof)     m_frames++;
      m_mode  = nm;
      m_kprev = rk;
   endtask

   task automatic step();
      bit sof;
      sof = (cyc % SOF) == SOF - 1;
      bus.startOfFrame    = sof;
      bus.player_dead     = pd;
      bus.enemies_cleared = ec;
      bus.restart_key     = rk;
      @(posedge clk);
      if (!resetN) model_reset();
      else         model_edge(sof);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until(input int mode, input int limit, input string tag);
      int k;
      k = 0;
      while (m_mode != mode && k < limit) begin
         step();
         k++;
      end
      check(tag, m_mode == mode, 1'b1);
   endtask

   task automatic key_pulse();
      rk = 1'b1; step(); rk = 1'b0;
   endtask

   initial begin
      bus.startOfFrame    = 1'b0;
      bus.player_dead     = 1'b0;
      bus.enemies_cleared = 1'b0;
      bus.restart_key     = 1'b0;
      model_reset();

      resetN = 1'b0;
      steps(3);
      check("reset_game_over",    bus.game_over,    1'b0);
      check("reset_game_won",     bus.game_won,     1'b0);
      check("reset_freeze_game",  bus.freeze_game,  1'b0);
      check("reset_restart_game", bus.restart_game, 1'b0);
      resetN = 1'b1;
      steps(5);

      // loss: freeze next cycle, early key ignored, key after minimum restarts
      pd = 1'b1; step(); pd = 1'b0;
      check("loss_freeze", bus.freeze_game, 1'b1);
      check("loss_won",    bus.game_won,    1'b0);
      run_until(M_BANNER, 60, "loss_reach_banner");
      check("loss_banner_on", bus.game_over, 1'b1);
      steps(2 * SOF);
      key_pulse();
      check("early_key_ignored", bus.restart_game, 1'b0);
      steps(2 * SOF);
      key_pulse();
      check("restart_pulse", bus.restart_game, 1'b1);
      step();
      check("restart_one_cycle", bus.restart_game, 1'b0);
      check("restart_unfreeze",  bus.freeze_game,  1'b0);
      check("restart_won_clear", bus.game_won,     1'b0);
      steps(4);

      // win
      ec = 1'b1; step(); ec = 1'b0;
      check("win_won", bus.game_won, 1'b1);
      run_until(M_BANNER, 60, "win_reach_banner");
      check("win_banner_won", bus.game_won, 1'b1);
      steps(4 * SOF + 3);
      key_pulse();
      check("win_restart_pulse", bus.restart_game, 1'b1);
      check("win_won_drops",     bus.game_won,     1'b0);
      steps(4);

      // simultaneous events: loss wins
      pd = 1'b1; ec = 1'b1; step(); pd = 1'b0; ec = 1'b0;
      check("both_won_zero", bus.game_won, 1'b0);
      run_until(M_BANNER, 60, "both_reach_banner");
      steps(5 * SOF);
      key_pulse();
      check("both_restart", bus.restart_game, 1'b1);
      steps(4);

      // key held since PLAY never triggers; fresh press does
      rk = 1'b1;
      steps(3);
      pd = 1'b1; step(); pd = 1'b0;
      run_until(M_BANNER, 60, "held_reach_banner");
      steps(10 * SOF);
      check("held_no_restart", bus.freeze_game, 1'b1);
      rk = 1'b0; step();
      rk = 1'b1; step();
      check("fresh_press_restart", bus.restart_game, 1'b1);
      rk = 1'b0;
      steps(4);

      // asynchronous reset mid-banner
      ec = 1'b1; step(); ec = 1'b0;
      run_until(M_BANNER, 60, "areset_reach_banner");
      steps(4 * SOF + 5);
      #2 resetN = 1'b0;
      #1;
      check("areset_game_over",    bus.game_over,    1'b0);
      check("areset_game_won",     bus.game_won,     1'b0);
      check("areset_freeze_game",  bus.freeze_game,  1'b0);
      check("areset_restart_game", bus.restart_game, 1'b0);
      model_reset();
      steps(2);
      resetN = 1'b1;
      steps(3);

      // randomized events and key activity
      for (int i = 0; i < 3000; i++) begin
         pd = ($urandom_range(0, 59) == 0);
         ec = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 11) == 0) rk = ~rk;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
